// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - command FIFO plus strobe sequencer for the 3-bit ALU
// Define ALU_CHECK_EN to compare each captured result against an internal ALU model.

module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 9
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push_valid,
  output logic                       o_push_ready,
  input  logic [W-1:0]               i_push_data,
  input  logic                       i_pop,
  output logic                       o_empty,
  output logic [W-1:0]               o_head,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;

  assign o_push_ready = (r_count != CW'(DEPTH));
  assign o_empty      = (r_count == '0);
  assign o_head       = r_mem[r_rd_ptr];
  assign o_count      = r_count;
  assign w_push       = i_push_valid && o_push_ready;

  // Storage is left unreset; only pointers and count define validity.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module alu_cmd_issuer #(
  parameter int DEPTH     = 4,
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 2,
  parameter int WAIT_CYC  = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_cmd_valid,
  output logic                       o_cmd_ready,
  input  logic [2:0]                 i_cmd_op,
  input  logic [2:0]                 i_cmd_a,
  input  logic [2:0]                 i_cmd_b,
  output logic [2:0]                 o_alu_opcode,
  output logic [2:0]                 o_alu_a,
  output logic [2:0]                 o_alu_b,
  output logic                       o_alu_execute,
  input  logic [5:0]                 i_alu_f,
  input  logic [2:0]                 i_alu_opcodesel,
  output logic                       o_res_valid,
  input  logic                       i_res_ready,
  output logic [5:0]                 o_res_f,
  output logic [2:0]                 o_res_op,
  output logic                       o_res_op_err,
  output logic                       o_res_mismatch,
  output logic                       o_busy,
  output logic [$clog2(DEPTH):0]     o_fifo_count
);
  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_WAIT, S_CAPTURE
  } state_t;

  state_t         r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]     r_opcode;
  logic [2:0]     r_a;
  logic [2:0]     r_b;
  logic           r_execute;
  logic           r_res_valid;
  logic [5:0]     r_res_f;
  logic [2:0]     r_res_op;
  logic           r_res_op_err;
  logic           r_res_mismatch;

  logic           w_empty;
  logic           w_pop;
  logic [8:0]     w_head;
  logic           w_mismatch;

  alu_cmd_fifo #(.DEPTH(DEPTH), .W(9)) u_fifo (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_push_valid (i_cmd_valid),
    .o_push_ready (o_cmd_ready),
    .i_push_data  ({i_cmd_op, i_cmd_a, i_cmd_b}),
    .i_pop        (w_pop),
    .o_empty      (w_empty),
    .o_head       (w_head),
    .o_count      (o_fifo_count)
  );

  assign w_pop = (r_state == S_IDLE) && !w_empty;

`ifdef ALU_CHECK_EN
  logic [5:0] w_ea;
  logic [5:0] w_eb;
  logic [5:0] w_expected;

  assign w_ea = {3'b000, r_a};
  assign w_eb = {3'b000, r_b};

  // All arithmetic is in 6-bit context, so SUB and SHL wrap modulo 64.
  always_comb begin
    w_expected = 6'd0;
    case (r_opcode)
      3'b001:  w_expected = w_ea + w_eb;
      3'b010:  w_expected = w_ea - w_eb;
      3'b011:  w_expected = w_ea * w_eb;
      3'b100:  w_expected = w_ea >> r_b;
      3'b101:  w_expected = w_ea << r_b;
      3'b110:  w_expected = {3'b111, r_a ~^ r_b};
      3'b111:  w_expected = {5'b00000, (r_a > r_b)};
      default: w_expected = 6'd0;
    endcase
  end

  assign w_mismatch = (i_alu_f != w_expected);
`else
  assign w_mismatch = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_opcode       <= '0;
      r_a            <= '0;
      r_b            <= '0;
      r_execute      <= 1'b0;
      r_res_valid    <= 1'b0;
      r_res_f        <= '0;
      r_res_op       <= '0;
      r_res_op_err   <= 1'b0;
      r_res_mismatch <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            {r_opcode, r_a, r_b} <= w_head;
            r_cnt   <= '0;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (r_cnt == CNT_W'(SETUP_CYC - 1)) begin
            r_cnt     <= '0;
            r_execute <= 1'b1;
            r_state   <= S_PULSE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_PULSE: begin
          if (r_cnt == CNT_W'(PULSE_CYC - 1)) begin
            r_cnt     <= '0;
            r_execute <= 1'b0;
            r_state   <= S_WAIT;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_WAIT: begin
          // The ALU outputs are sampled only here, after the full settle time.
          if (r_cnt == CNT_W'(WAIT_CYC - 1)) begin
            r_cnt          <= '0;
            r_res_f        <= i_alu_f;
            r_res_op       <= r_opcode;
            r_res_op_err   <= (i_alu_opcodesel != r_opcode);
            r_res_mismatch <= w_mismatch;
            r_res_valid    <= 1'b1;
            r_state        <= S_CAPTURE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_CAPTURE: begin
          if (i_res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_execute <= 1'b0;
        end
      endcase
    end
  end

  assign o_alu_opcode   = r_opcode;
  assign o_alu_a        = r_a;
  assign o_alu_b        = r_b;
  assign o_alu_execute  = r_execute;
  assign o_res_valid    = r_res_valid;
  assign o_res_f        = r_res_f;
  assign o_res_op       = r_res_op;
  assign o_res_op_err   = r_res_op_err;
  assign o_res_mismatch = r_res_mismatch;
  assign o_busy         = (r_state != S_IDLE) || !w_empty;
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb/tb_alu_cmd_issuer.sv - scoreboard bench for alu_cmd_issuer with a behavioural ALU
module tb_alu_cmd_issuer;
  logic       i_clk, i_rst, i_cmd_valid, o_cmd_ready;
  logic [2:0] i_cmd_op, i_cmd_a, i_cmd_b;
  logic [2:0] o_alu_opcode, o_alu_a, o_alu_b;
  logic       o_alu_execute;
  logic [5:0] i_alu_f;
  logic [2:0] i_alu_opcodesel;
  logic       o_res_valid, i_res_ready;
  logic [5:0] o_res_f;
  logic [2:0] o_res_op;
  logic       o_res_op_err, o_res_mismatch, o_busy;
  logic [2:0] o_fifo_count;

  alu_cmd_issuer dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_op(i_cmd_op), .i_cmd_a(i_cmd_a), .i_cmd_b(i_cmd_b),
    .o_alu_opcode(o_alu_opcode), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b),
    .o_alu_execute(o_alu_execute), .i_alu_f(i_alu_f), .i_alu_opcodesel(i_alu_opcodesel),
    .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_res_f(o_res_f),
    .o_res_op(o_res_op), .o_res_op_err(o_res_op_err), .o_res_mismatch(o_res_mismatch),
    .o_busy(o_busy), .o_fifo_count(o_fifo_count)
  );

  typedef struct {
    int f;
    int op;
    int err;
    int mm;
  } exp_t;

  exp_t exp_q[$];
  int   fault_q[$];   // 0 = honest ALU, 1 = echo opcode 000, 2 = force f to 0
  int   checks = 0;
  int   errors = 0;
  int   rdy_mode = 1; // 0 = hold low, 1 = hold high, 2 = random

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic int ref_alu(input int op, input int a, input int b);
    case (op)
      1: return a + b;
      2: return (a - b + 64) % 64;
      3: return a * b;
      4: return a / (2 ** b);
      5: return (a * (2 ** b)) % 64;
      6: return 56 + (7 - (a ^ b));
      7: return (a > b) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic exp_t make_exp(input int op, input int a, input int b, input int fault);
    exp_t e;
    int   r;
    r     = ref_alu(op, a, b);
    e.f   = (fault == 2) ? 0 : r;
    e.op  = op;
    e.err = (fault == 1 && op != 0) ? 1 : 0;
`ifdef ALU_CHECK_EN
    e.mm  = (e.f != r) ? 1 : 0;
`else
    e.mm  = 0;
`endif
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic push(input int op, input int a, input int b, input int fault);
    bit done;
    int opv, av, bv;
    done = 0;
    opv = op; av = a; bv = b;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge i_clk);
      i_cmd_valid = 1'b1;
      i_cmd_op    = opv[2:0];
      i_cmd_a     = av[2:0];
      i_cmd_b     = bv[2:0];
      if (o_cmd_ready) begin
        exp_q.push_back(make_exp(op, a, b, fault));
        fault_q.push_back(fault);
        @(posedge i_clk);
        #1 i_cmd_valid = 1'b0;
        done = 1;
      end
    end
    i_cmd_valid = 1'b0;
    check("push_accept", int'(done), 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int n = 0; n < 2000 && !ok; n++) begin
      @(negedge i_clk);
      #1;
      if (exp_q.size() == 0 && !o_busy && !o_res_valid) ok = 1;
    end
    check("drain_done", int'(ok), 1);
  endtask

  // Behavioural ALU: computes on the execute rising edge, optionally misbehaving.
  initial begin
    int flt, r;
    i_alu_f = '0;
    i_alu_opcodesel = '0;
    forever begin
      @(posedge o_alu_execute);
      flt = (fault_q.size() > 0) ? fault_q.pop_front() : 0;
      r   = ref_alu(int'(o_alu_opcode), int'(o_alu_a), int'(o_alu_b));
      if (flt == 2) r = 0;
      i_alu_f = r[5:0];
      i_alu_opcodesel = (flt == 1) ? 3'b000 : o_alu_opcode;
    end
  end

  initial begin
    i_res_ready = 1'b1;
    forever begin
      @(negedge i_clk);
      case (rdy_mode)
        0: i_res_ready = 1'b0;
        1: i_res_ready = 1'b1;
        default: i_res_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on each result handshake and checks stall stability.
  initial begin
    bit   stall;
    int   sf, sop, serr, smm;
    exp_t e;
    stall = 0;
    sf = 0; sop = 0; serr = 0; smm = 0;
    forever begin
      @(negedge i_clk);
      #1;
      if (i_rst) begin
        stall = 0;
      end else begin
        if (stall) begin
          check("stall_valid", int'(o_res_valid), 1);
          check("stall_f", int'(o_res_f), sf);
          check("stall_op", int'(o_res_op), sop);
          check("stall_err", int'(o_res_op_err), serr);
          check("stall_mm", int'(o_res_mismatch), smm);
        end
        if (o_res_valid && i_res_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("res_f", int'(o_res_f), e.f);
            check("res_op", int'(o_res_op), e.op);
            check("res_op_err", int'(o_res_op_err), e.err);
            check("res_mismatch", int'(o_res_mismatch), e.mm);
          end
        end
        stall = o_res_valid && !i_res_ready;
        sf = int'(o_res_f); sop = int'(o_res_op);
        serr = int'(o_res_op_err); smm = int'(o_res_mismatch);
      end
    end
  end

  initial begin
    int first_ex, ex_hi, first_v;
    bit seen;
    i_rst = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_op = '0; i_cmd_a = '0; i_cmd_b = '0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check("rst_cmd_ready", int'(o_cmd_ready), 1);
    check("rst_busy", int'(o_busy), 0);
    check("rst_count", int'(o_fifo_count), 0);
    check("rst_res_valid", int'(o_res_valid), 0);
    check("rst_execute", int'(o_alu_execute), 0);
    check("rst_res_f", int'(o_res_f), 0);

    // Single ADD: latency and pulse width relative to the pop cycle.
    push(1, 3, 4, 0);
    first_ex = -1; ex_hi = 0; first_v = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      #1;
      if (i == 0) check("busy_on_pop", int'(o_busy), 1);
      if (i == 1) check("operands", int'({o_alu_opcode, o_alu_a, o_alu_b}), 9'o134);
      if (o_alu_execute) begin
        if (first_ex < 0) first_ex = i;
        ex_hi++;
      end
      if (o_res_valid && first_v < 0) first_v = i;
    end
    check("exec_rise_lat", first_ex, 3);
    check("exec_width", ex_hi, 2);
    check("res_valid_lat", first_v, 7);
    wait_idle();

    push(2, 2, 5, 0);
    push(6, 5, 3, 0);
    push(5, 7, 4, 0);
    push(3, 7, 7, 0);
    wait_idle();

    // Stalled result: FIFO fills behind the in-flight command.
    rdy_mode = 0;
    for (int k = 0; k < 5; k++) push(1 + k, k + 1, 6 - k, 0);
    repeat (12) @(negedge i_clk);
    #1;
    check("full_count", int'(o_fifo_count), 4);
    check("full_ready", int'(o_cmd_ready), 0);
    check("stalled_valid", int'(o_res_valid), 1);
    rdy_mode = 1;
    push(4, 7, 1, 0);
    wait_idle();

    push(7, 6, 1, 1);
    wait_idle();

    // Reset during PULSE with two commands queued.
    push(1, 1, 1, 0);
    push(2, 3, 1, 0);
    push(3, 2, 2, 0);
    seen = 0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge i_clk);
      if (o_alu_execute) seen = 1;
    end
    check("reached_pulse", int'(seen), 1);
    check("queued_before_rst", int'(o_fifo_count), 2);
    i_rst = 1'b1;
    exp_q.delete();
    fault_q.delete();
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check("mid_rst_execute", int'(o_alu_execute), 0);
    check("mid_rst_count", int'(o_fifo_count), 0);
    check("mid_rst_valid", int'(o_res_valid), 0);
    check("mid_rst_ready", int'(o_cmd_ready), 1);
    repeat (30) @(negedge i_clk);
    #1;
    check("post_rst_idle", int'(o_busy), 0);

    push(3, 3, 3, 2);
    wait_idle();

    rdy_mode = 2;
    for (int k = 0; k < 40; k++) begin
      int flt;
      flt = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
      push(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)), flt);
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
